// File: rtl/uart_rs232_rx.sv
// UART RS-232 receiver: 16x-oversampled, 1 start bit, 1..8 data bits LSB first, 1 stop bit.
// Reports each completed frame with a one-clock RxDone pulse and a FrameErr qualifier.
module uart_rs232_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MID_TICK    = 7
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       RxEn,
    input  logic       Rx,
    input  logic [3:0] NBits,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       FrameErr,
    output logic       Busy,
    output logic [1:0] DbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [3:0] MID = 4'(MID_TICK);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] nbits_q, nbits_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] data_d;
    logic       err_d;
    logic       done_d;
    logic [3:0] nbits_eff;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign nbits_eff = (NBits == 4'd0 || NBits > 4'd8) ? 4'd8 : NBits;
    assign Busy      = (state_q != IDLE);
    assign DbgState  = state_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q   <= '1;
            rx_prev  <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            bit_q    <= 3'd0;
            nbits_q  <= 4'd8;
            sr_q     <= 8'h00;
            RxData   <= 8'h00;
            RxDone   <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], Rx};
            rx_prev  <= rx_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            nbits_q  <= nbits_d;
            sr_q     <= sr_d;
            RxData   <= data_d;
            RxDone   <= done_d;
            FrameErr <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        sr_d    = sr_q;
        data_d  = RxData;
        err_d   = FrameErr;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a fresh high-to-low edge starts a frame; a held-low line never does.
                if (RxEn && rx_prev && !rx_s) begin
                    state_d = START;
                    cnt_d   = 4'd0;
                    nbits_d = nbits_eff;
                end
            end
            START: begin
                if (Tick) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            cnt_d   = 4'd0;
                            bit_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (Tick) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        sr_d  = {rx_s, sr_q[7:1]};
                        bit_d = bit_q + 3'd1;
                        if ({1'b0, bit_q} == nbits_q - 4'd1) begin
                            state_d = STOP;
                            cnt_d   = 4'd0;
                        end
                    end
                end
            end
            STOP: begin
                if (Tick) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        // Bits entered at the MSB, so short words are right-aligned here.
                        data_d  = sr_q >> (4'd8 - nbits_q);
                        err_d   = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rs232_rx.sv
// Directed bench for uart_rs232_rx: frames are driven bit by bit on a 16-tick grid,
// completed frames are captured at the falling clock edge and compared per scenario.
`timescale 1ns/1ps
module tb_uart_rs232_rx;

    logic       Clk;
    logic       Rst;
    logic       Tick;
    logic       RxEn;
    logic       Rx;
    logic [3:0] NBits;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       Busy;
    logic [1:0] DbgState;

    int checks   = 0;
    int failures = 0;
    int width_err = 0;
    logic done_prev = 1'b0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    uart_rs232_rx #(.SYNC_STAGES(2), .MID_TICK(7)) dut (
        .Clk(Clk), .Rst(Rst), .Tick(Tick), .RxEn(RxEn), .Rx(Rx), .NBits(NBits),
        .RxData(RxData), .RxDone(RxDone), .FrameErr(FrameErr), .Busy(Busy), .DbgState(DbgState)
    );

    // clock / reset / tick
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        Tick = 1'b0;
        forever begin
            repeat (3) @(negedge Clk);
            Tick = 1'b1;
            @(negedge Clk);
            Tick = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // capture completed frames as {FrameErr, RxData}
    always @(negedge Clk) begin
        if (RxDone) got_q.push_back({FrameErr, RxData});
        if (RxDone && done_prev) width_err++;
        done_prev = RxDone;
    end

    // driver tasks
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge Clk); while (Tick !== 1'b1);
        end
        @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nb, input logic stop_bit);
        Rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nb; i++) begin
            Rx = data[i];
            wait_ticks(16);
        end
        Rx = stop_bit;
        wait_ticks(16);
    endtask

    task automatic compare_frames(input string name);
        logic [8:0] g, e;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s_frame got=err%b/%h exp=err%b/%h", name, g[8], g[7:0], e[8], e[7:0]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // scenarios
    task automatic test_reset();
        Rst = 1'b1; Rx = 1'b1; RxEn = 1'b0; NBits = 4'd8;
        repeat (3) @(negedge Clk);
        checks++; if (RxData !== 8'h00) begin failures++; $display("FAIL reset_rxdata got=%h exp=00", RxData); end
        checks++; if (RxDone !== 1'b0) begin failures++; $display("FAIL reset_rxdone got=%b exp=0", RxDone); end
        checks++; if (FrameErr !== 1'b0) begin failures++; $display("FAIL reset_frameerr got=%b exp=0", FrameErr); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (DbgState !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", DbgState); end
        Rst = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_basic_a5();
        NBits = 4'd8; RxEn = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 8, 1'b1);
        wait_ticks(2);
        compare_frames("a5");
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL a5_busy got=%b exp=0", Busy); end
        checks++; if (width_err != 0) begin failures++; $display("FAIL a5_pulse_width got=%0d exp=0", width_err); end
    endtask

    task automatic test_nbits5();
        NBits = 4'd5;
        exp_q.push_back({1'b0, 8'h13});
        fork
            send_frame(8'h13, 5, 1'b1);
            begin
                wait_ticks(20);
                NBits = 4'd8;
            end
        join
        wait_ticks(2);
        compare_frames("nbits5");
    endtask

    task automatic test_glitch();
        Rx = 1'b0;
        wait_ticks(2);
        checks++; if (DbgState !== 2'd1) begin failures++; $display("FAIL glitch_in_start got=%0d exp=1", DbgState); end
        wait_ticks(1);
        Rx = 1'b1;
        wait_ticks(12);
        checks++; if (DbgState !== 2'd0) begin failures++; $display("FAIL glitch_idle got=%0d exp=0", DbgState); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_nodone got=%0d exp=0", got_q.size()); end
        got_q.delete();
        wait_ticks(8);
        NBits = 4'd0;
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 8, 1'b1);
        wait_ticks(2);
        compare_frames("glitch_3c");
        NBits = 4'd8;
    endtask

    task automatic test_frame_error();
        NBits = 4'd8;
        exp_q.push_back({1'b1, 8'h00});
        send_frame(8'h00, 8, 1'b0);
        wait_ticks(40);
        compare_frames("ferr");
        checks++; if (DbgState !== 2'd0) begin failures++; $display("FAIL ferr_break_idle got=%0d exp=0", DbgState); end
        checks++; if (FrameErr !== 1'b1) begin failures++; $display("FAIL ferr_held got=%b exp=1", FrameErr); end
        Rx = 1'b1;
        wait_ticks(16);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 8, 1'b1);
        wait_ticks(2);
        compare_frames("ferr_81");
    endtask

    task automatic test_reset_midframe();
        fork
            send_frame(8'hFF, 8, 1'b1);
            begin
                wait_ticks(84);
                checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL rst_busy_before got=%b exp=1", Busy); end
                Rst = 1'b1;
                #1;
                checks++; if (RxData !== 8'h00) begin failures++; $display("FAIL rst_rxdata got=%h exp=00", RxData); end
                checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", Busy); end
                checks++; if (DbgState !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", DbgState); end
                checks++; if (FrameErr !== 1'b0) begin failures++; $display("FAIL rst_frameerr got=%b exp=0", FrameErr); end
                @(negedge Clk);
                Rst = 1'b0;
            end
        join
        wait_ticks(4);
        compare_frames("rst_nodone");
        exp_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 8, 1'b1);
        wait_ticks(2);
        compare_frames("rst_5a");
    endtask

    task automatic test_back_to_back();
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'hEE});
        send_frame(8'h11, 8, 1'b1);
        send_frame(8'hEE, 8, 1'b1);
        wait_ticks(4);
        RxEn = 1'b0;
        send_frame(8'h33, 8, 1'b1);
        wait_ticks(4);
        compare_frames("b2b");
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL b2b_disabled_busy got=%b exp=0", Busy); end
        checks++; if (width_err != 0) begin failures++; $display("FAIL b2b_pulse_width got=%0d exp=0", width_err); end
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_nbits5();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
